// File: rtl/led_fader_pkg.sv
// led_fader_pkg: shared PWM range, saturating brightness arithmetic and gamma curve for led_fader
package led_fader_pkg;
  function automatic int unsigned pwm_max(input int unsigned w);
    return (32'd1 << w) - 32'd1;
  endfunction
  function automatic int unsigned sat_add(input int unsigned a, input int unsigned s, input int unsigned m);
    return (a + s > m) ? m : a + s;
  endfunction
  function automatic int unsigned sat_sub(input int unsigned a, input int unsigned s);
    return (a > s) ? a - s : 32'd0;
  endfunction
  // Full scale maps to itself so a fully-on LED stays constantly on
  function automatic int unsigned gamma(input int unsigned s, input int unsigned w);
    return (s == pwm_max(w)) ? s : (s * s) >> w;
  endfunction
endpackage

// File: rtl/led_fader_channel.sv
// led_fader_channel: one LED's brightness ramp, period-aligned shadow and PWM compare; LED_FADER_GAMMA_EN adds a gamma stage
module led_fader_channel
  import led_fader_pkg::*;
#(
  parameter int unsigned PWM_WIDTH = 8,
  parameter int unsigned STEP      = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 target,
  input  logic                 fade_tick,
  input  logic                 pwm_wrap,
  input  logic [PWM_WIDTH-1:0] pwm_cnt,
  output logic                 led,
  output logic                 busy
);
  localparam int unsigned MAX = pwm_max(PWM_WIDTH);
  logic [PWM_WIDTH-1:0] bright, shadow, bright_n, cmp, cnt;
  always_comb bright_n = PWM_WIDTH'(target ? sat_add(32'(bright), STEP, MAX) : sat_sub(32'(bright), STEP));
  always_comb busy = target ? (bright != PWM_WIDTH'(MAX)) : (bright != '0);
  // Shadow samples the pre-update brightness so duty only changes at a period boundary
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      bright <= '0;
      shadow <= '0;
    end else begin
      if (fade_tick) bright <= bright_n;
      if (pwm_wrap) shadow <= bright;
    end
`ifdef LED_FADER_GAMMA_EN
  logic [PWM_WIDTH-1:0] cmp_q, cnt_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cmp_q <= '0;
      cnt_q <= '0;
    end else begin
      cmp_q <= PWM_WIDTH'(gamma(32'(shadow), PWM_WIDTH));
      cnt_q <= pwm_cnt;
    end
  assign cmp = cmp_q;
  assign cnt = cnt_q;
`else
  assign cmp = shadow;
  assign cnt = pwm_cnt;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) led <= 1'b0;
    else led <= cmp > cnt;
endmodule

// File: rtl/led_fader.sv
// led_fader: fades each LED toward its led_i target with glitch-free PWM; define LED_FADER_GAMMA_EN for gamma-corrected duty
module led_fader
  import led_fader_pkg::*;
#(
  parameter int unsigned NB_LED    = 8,
  parameter int unsigned PWM_WIDTH = 8,
  parameter int unsigned FADE_DIV  = 98_000,
  parameter int unsigned STEP      = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [NB_LED-1:0] led_i,
  output logic [NB_LED-1:0] led_o,
  output logic              busy_o
);
  localparam int unsigned PW = FADE_DIV > 1 ? $clog2(FADE_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(FADE_DIV - 1);
  localparam logic [PWM_WIDTH-1:0] CNT_LAST = PWM_WIDTH'(pwm_max(PWM_WIDTH) - 1);
  logic [PW-1:0] pre;
  logic [PWM_WIDTH-1:0] pwm_cnt;
  logic fade_tick, pwm_wrap;
  logic [NB_LED-1:0] busy;
  assign fade_tick = pre == PRE_LAST;
  assign pwm_wrap = pwm_cnt == CNT_LAST;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      pre <= '0;
      pwm_cnt <= '0;
      busy_o <= 1'b0;
    end else begin
      pre <= fade_tick ? '0 : pre + PW'(1);
      pwm_cnt <= pwm_wrap ? '0 : pwm_cnt + PWM_WIDTH'(1);
      busy_o <= |busy;
    end
  for (genvar k = 0; k < NB_LED; k++) begin : g_ch
    led_fader_channel #(.PWM_WIDTH(PWM_WIDTH), .STEP(STEP)) u_ch (
      .clk(clk_i),
      .rst(rst_i),
      .target(led_i[k]),
      .fade_tick(fade_tick),
      .pwm_wrap(pwm_wrap),
      .pwm_cnt(pwm_cnt),
      .led(led_o[k]),
      .busy(busy[k])
    );
  end
endmodule

// File: tb/tb_led_fader.sv
// tb_led_fader: scoreboard bench for led_fader, STEP=1 and STEP=4 instances with hand-computed per-period duty tables
module tb_led_fader;
`ifdef LED_FADER_GAMMA_EN
  localparam int L = 2;
  localparam bit G = 1'b1;
`else
  localparam int L = 1;
  localparam bit G = 1'b0;
`endif
  typedef struct {int c; logic [8:0] v;} exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] led_a = '0, led_b = '0, out_a, out_b;
  logic busy_a, busy_b;
  int cyc, pass_n = 0, tot_n = 0;
  int sh_a[8][7], sh_b[8][7], ba[2][2], bb[2][2];
  exp_t qa[$], qb[$], em;
  always #5 clk = ~clk;
  led_fader #(.NB_LED(8), .PWM_WIDTH(4), .FADE_DIV(4), .STEP(1)) dut_a (
    .clk_i(clk), .rst_i(rst), .led_i(led_a), .led_o(out_a), .busy_o(busy_a));
  led_fader #(.NB_LED(8), .PWM_WIDTH(4), .FADE_DIV(4), .STEP(4)) dut_b (
    .clk_i(clk), .rst_i(rst), .led_i(led_b), .led_o(out_b), .busy_o(busy_b));
  always @(posedge clk or posedge rst)
    if (rst) cyc <= 0;
    else cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  function automatic logic exp_bit(input int sh, input int p);
    int cmp;
    cmp = G ? ((sh == 15) ? 15 : (sh * sh) >> 4) : sh;
    return cmp > p;
  endfunction
  function automatic logic in_iv(input int c, input int iv[2][2]);
    return (c >= iv[0][0] && c <= iv[0][1]) || (c >= iv[1][0] && c <= iv[1][1]);
  endfunction
  // Expected {led_o, busy_o} after clock edge c: period j shows shadow_j, compared against position p
  task automatic push_run(input int n);
    exp_t e;
    int j, p;
    for (int c = 1; c <= n; c++) begin
      j = (c >= L) ? (c - L) / 15 : 0;
      p = (c >= L) ? (c - L) % 15 : 0;
      e.c = c;
      for (int k = 0; k < 8; k++) e.v[k+1] = exp_bit(sh_a[k][j], p);
      e.v[0] = in_iv(c, ba);
      qa.push_back(e);
      for (int k = 0; k < 8; k++) e.v[k+1] = exp_bit(sh_b[k][j], p);
      e.v[0] = in_iv(c, bb);
      qb.push_back(e);
    end
  endtask
  task automatic at_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask
  always @(negedge clk)
    if (!rst) begin
      while (qa.size() > 0 && qa[0].c <= cyc) begin
        em = qa.pop_front();
        chk($sformatf("a_c%0d", em.c), {out_a, busy_a}, em.v);
      end
      while (qb.size() > 0 && qb[0].c <= cyc) begin
        em = qb.pop_front();
        chk($sformatf("b_c%0d", em.c), {out_b, busy_b}, em.v);
      end
    end
  initial begin
    #100000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_a", {out_a, busy_a}, 0);
    chk("rst_b", {out_b, busy_b}, 0);
    led_a = 8'h03;
    led_b = 8'h09;
    sh_a[0] = '{0, 3, 7, 11, 14, 15, 15};
    sh_a[1] = '{0, 3, 7, 7, 4, 0, 0};
    sh_a[2] = '{0, 1, 5, 1, 0, 0, 0};
    sh_b[0] = '{0, 12, 15, 15, 3, 0, 0};
    sh_b[1] = '{0, 8, 15, 15, 7, 0, 0};
    sh_b[2] = '{0, 4, 15, 15, 11, 0, 0};
    sh_b[3] = '{0, 12, 15, 15, 15, 0, 0};
    ba = '{'{1, 72}, '{0, -1}};
    bb = '{'{1, 24}, '{45, 72}};
    push_run(104);
    @(negedge clk);
    chk("rst_hold_a", {out_a, busy_a}, 0);
    chk("rst_hold_b", {out_b, busy_b}, 0);
    rst = 1'b0;
    at_cyc(4);  led_b[1] = 1'b1;
    at_cyc(8);  led_a[2] = 1'b1; led_b[2] = 1'b1;
    at_cyc(28); led_a[2] = 1'b0;
    at_cyc(36); led_a[1] = 1'b0;
    at_cyc(44); led_b[0] = 1'b0;
    at_cyc(48); led_b[1] = 1'b0;
    at_cyc(52); led_b[2] = 1'b0;
    at_cyc(56); led_b[3] = 1'b0;
    at_cyc(110);
    chk("drain1", qa.size() + qb.size(), 0);
    chk("pre_rst_a", out_a, 8'h01);
    #1 rst = 1'b1;
    #1 chk("async_rst_a", {out_a, busy_a}, 0);
    chk("async_rst_b", {out_b, busy_b}, 0);
    for (int k = 0; k < 8; k++) for (int j = 0; j < 7; j++) begin
      sh_a[k][j] = 0;
      sh_b[k][j] = 0;
    end
    sh_a[0] = '{0, 3, 7, 11, 14, 15, 15};
    ba = '{'{1, 60}, '{0, -1}};
    bb = '{'{0, -1}, '{0, -1}};
    led_b = 8'h00;
    push_run(62);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    at_cyc(66);
    chk("drain2", qa.size() + qb.size(), 0);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule

// File: doc/led_fader.md
Name: led_fader

Overview:
- Downstream stage of the 8-LED counter blinker: consumes its 8-bit LED pattern and drives the physical LED pins.
- Each LED bit selects a target: 1 = fade in, 0 = fade out. The block ramps a per-LED brightness towards that target and outputs glitch-free PWM.
- Sits between the counter's LED output and the top-level LED pins, in the same clock domain.

Parameters:
- NB_LED, 8, number of LED channels.
- PWM_WIDTH, 8, brightness and PWM counter width. PWM_MAX = 2^PWM_WIDTH - 1.
- FADE_DIV, 98_000, clk cycles between brightness steps (≥1). Full ramp takes PWM_MAX*FADE_DIV cycles.
- STEP, 1, brightness increment/decrement per fade tick (1..PWM_MAX).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  asynchronous, active-high reset.
- led_i  in  NB_LED  target pattern, synchronous to clk_i, no resync.
- led_o  out  NB_LED  registered PWM LED drive.
- busy_o  out  1  registered; 1 while any brightness ≠ its target end value (0 or PWM_MAX).

Behaviour:
- Reset (async assert, sync to clk_i on release) clears all of the following to 0:
  - prescaler, pwm_cnt, every bright[k], every shadow[k];
  - led_o and busy_o.
- Prescaler:
  - counts 0..FADE_DIV-1 and wraps to 0.
  - fade_tick = 1 for exactly one cycle when the prescaler equals FADE_DIV-1.
  - FADE_DIV=1 gives a tick every cycle.
- PWM counter:
  - pwm_cnt counts 0..PWM_MAX-1 and wraps to 0. Period is PWM_MAX cycles.
  - pwm_wrap = (pwm_cnt == PWM_MAX-1).
- Brightness update, per channel k, on fade_tick only:
  - led_i[k]=1: bright = min(bright+STEP, PWM_MAX). Compute in PWM_WIDTH+1 bits, then saturate.
  - led_i[k]=0: bright = max(bright-STEP, 0). No underflow wrap.
  - Already at the target end value: hold.
- Shadow:
  - on pwm_wrap, shadow[k] <= bright[k], the value before any same-edge update.
  - If fade_tick and pwm_wrap coincide, shadow takes the old bright; the new value applies from the following period.
  - bright changes never alter duty mid-period.
- Output:
  - led_o[k] <= (shadow[k] > pwm_cnt).
  - shadow=0 gives constant 0. shadow=PWM_MAX gives constant 1. shadow=n gives exactly n high cycles per period.
  - Latency: one register after the compare.
- busy_o <= OR over k of (led_i[k] ? bright[k]≠PWM_MAX : bright[k]≠0).
- led_i changing mid-ramp: direction reverses at the next fade_tick from the current bright. No restart.
- Reset mid-ramp: LEDs go dark immediately (async). The ramp restarts from 0 after release.

Optional Feature:
- Macro: LED_FADER_GAMMA_EN.
- Defined: compare value = (shadow*shadow) >> PWM_WIDTH, with a 2*PWM_WIDTH-bit product.
  - Exception: shadow=PWM_MAX forces constant on, so full brightness is preserved.
  - Gives perceptually linear fades. Adds one pipeline register, so output latency becomes 2 cycles after pwm_cnt.
  - pwm_cnt is delayed by the same stage so duty counts stay exact.
- Undefined: linear compare as above, 1-cycle latency.

Decomposition:
- Package led_fader_pkg holds:
  - PWM_MAX derivation function (width → 2^W-1);
  - saturating add/sub functions on PWM_WIDTH+1 bits;
  - the gamma function.
- Sub-module led_fader_channel, one instance per LED (generate loop):
  - contains bright, shadow, saturating update and compare/output register;
  - takes fade_tick, pwm_wrap and pwm_cnt from the shared top-level counters.

Test Plan (PWM_WIDTH=4 → PWM_MAX=15, FADE_DIV=4, STEP=1, NB_LED=8 unless stated):
- Reset, led_i=8'h00 held: led_o=0 and busy_o=0 at all times. Assert rst_i mid-cycle: led_o=0 before the next clk edge.
- led_i=8'h01 from reset:
  - bright[0] reaches 15 after exactly 15 fade ticks (60 cycles), then holds;
  - busy_o falls the cycle after saturation;
  - once shadow=15, led_o[0] is constantly 1.
- Duty accuracy: force ramp to bright=5, then measure one full period. led_o[0] is high exactly 5 of 15 cycles, starting at pwm_cnt=0, with no glitch within the period.
- Reversal: led_i[0]=1 until bright=9, then led_i=0. bright decreases 9→8→… on subsequent ticks and saturates at 0 without wrapping to 15.
- STEP=4 saturation: up sequence is 0,4,8,12,15; down sequence is 15,11,7,3,0. Also check fade_tick coinciding with pwm_wrap: shadow captures the pre-update value.
- LED_FADER_GAMMA_EN defined:
  - shadow=8 → compare value 4 → 4 high cycles per period; shadow=15 → constant on;
  - output latency is 2 cycles relative to pwm_cnt.
